// File: rtl/jregfile.sv
// jregfile: DEPTH x WIDTH register file, one write port, two registered read ports.
// Macro JREGFILE_BYPASS_EN selects write-first read-during-write; undefined gives read-first.
module jregfile #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re0,
    input  logic [AW-1:0]    raddr0,
    output logic [WIDTH-1:0] rdata0,
    output logic             rvalid0,
    input  logic             re1,
    input  logic [AW-1:0]    raddr1,
    output logic [WIDTH-1:0] rdata1,
    output logic             rvalid1
);

    localparam logic [AW:0] DEPTH_V = DEPTH[AW:0];

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [WIDTH-1:0] rdata0_q, rdata0_d;
    logic [WIDTH-1:0] rdata1_q, rdata1_d;
    logic             rvalid0_q, rvalid0_d;
    logic             rvalid1_q, rvalid1_d;
    logic             wr_hit_s;

    function automatic logic in_range(input logic [AW-1:0] addr);
        return ({1'b0, addr} < DEPTH_V);
    endfunction

    // Addresses beyond DEPTH read as zero; a same-edge write is forwarded only in the bypass build.
    function automatic logic [WIDTH-1:0] read_word(input logic [AW-1:0] raddr);
        logic [WIDTH-1:0] word;
        word = '0;
        if (!in_range(raddr)) begin
            word = '0;
        end
`ifdef JREGFILE_BYPASS_EN
        else if (wr_hit_s && (waddr == raddr)) begin
            word = wdata;
        end
`endif
        else begin
            word = regs_q[raddr];
        end
        return word;
    endfunction

    assign wr_hit_s = we && in_range(waddr);

    // Next-state for storage array and both read ports.
    always_comb begin
        regs_d    = regs_q;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        rvalid0_d = re0;
        rvalid1_d = re1;
        if (wr_hit_s) begin
            regs_d[waddr] = wdata;
        end else begin
            regs_d = regs_q;
        end
        if (re0) begin
            rdata0_d = read_word(raddr0);
        end else begin
            rdata0_d = rdata0_q;
        end
        if (re1) begin
            rdata1_d = read_word(raddr1);
        end else begin
            rdata1_d = rdata1_q;
        end
    end

    // State registers; reset wins over any same-edge write or read.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            regs_q    <= regs_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
        end
    end

    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;
    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;

endmodule
